// File: rtl/jt51_csr_pkg.sv
// Shared types and constants for the per-channel CSR write scheduler.
// A queued write carries the target channel, the register group and the data byte.
package jt51_csr_pkg;

    localparam logic [7:0] CH_BASE = 8'h20;
    localparam logic [7:0] CH_LAST = 8'h3F;

    typedef enum logic [1:0] {
        GRP_RLFBCON = 2'd0,
        GRP_KC      = 2'd1,
        GRP_KF      = 2'd2,
        GRP_AMSPMS  = 2'd3
    } grp_t;

    typedef struct packed {
        logic [2:0] ch;
        grp_t       grp;
        logic [7:0] data;
    } ch_wr_t;

    localparam int CH_WR_W = $bits(ch_wr_t);

    function automatic logic is_ch_addr(input logic [7:0] addr);
        return (addr >= CH_BASE) && (addr <= CH_LAST);
    endfunction

endpackage

// File: rtl/jt51_csr_ch_sched_if.sv
// CPU-side write port of the channel CSR scheduler (valid/ready handshake).
interface jt51_csr_ch_sched_if;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_din;
    logic       wr_ready;

    modport master (output wr_valid, wr_addr, wr_din, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_din, output wr_ready);
endinterface

// File: rtl/jt51_sync_fifo.sv
// Small synchronous FIFO with registered occupancy count; DEPTH must be a power of 2.
module jt51_sync_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jt51_csr_ch_sched.sv
// Queues CPU writes to channel registers 0x20-0x3F and releases each one
// in the slot where its channel reaches the CSR ring input.
module jt51_csr_ch_sched
    import jt51_csr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cen,
    jt51_csr_ch_sched_if.slave  bus,
    output logic [2:0]          slot,
    output logic                busy,
    output logic [7:0]          din,
    output logic                up_rl_ch,
    output logic                up_fb_ch,
    output logic                up_con_ch,
    output logic                up_kc_ch,
    output logic                up_kf_ch,
    output logic                up_ams_ch,
    output logic                up_pms_ch
);

    localparam int AW = $clog2(DEPTH);

    ch_wr_t        wr_entry;
    ch_wr_t        head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [AW:0]   count;
    logic [2:0]    nxt;

    assign bus.wr_ready = !full;
    assign wr_entry     = '{ch: bus.wr_addr[2:0], grp: grp_t'(bus.wr_addr[4:3]), data: bus.wr_din};
    // Non-channel addresses complete the handshake but never enter the queue.
    assign push         = bus.wr_valid && !full && is_ch_addr(bus.wr_addr);
    assign nxt          = slot + 3'd1;
    assign pop          = cen && !empty && (head.ch == nxt);

    jt51_sync_fifo #(
        .WIDTH (CH_WR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wr_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign busy = (count != '0) | up_rl_ch | up_fb_ch | up_con_ch | up_kc_ch
                | up_kf_ch | up_ams_ch | up_pms_ch;

    // Strobes are computed for the slot being entered, so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot      <= 3'd0;
            din       <= 8'd0;
            up_rl_ch  <= 1'b0;
            up_fb_ch  <= 1'b0;
            up_con_ch <= 1'b0;
            up_kc_ch  <= 1'b0;
            up_kf_ch  <= 1'b0;
            up_ams_ch <= 1'b0;
            up_pms_ch <= 1'b0;
        end else if (cen) begin
            slot      <= nxt;
            up_rl_ch  <= 1'b0;
            up_fb_ch  <= 1'b0;
            up_con_ch <= 1'b0;
            up_kc_ch  <= 1'b0;
            up_kf_ch  <= 1'b0;
            up_ams_ch <= 1'b0;
            up_pms_ch <= 1'b0;
            if (pop) begin
                din <= head.data;
                case (head.grp)
                    GRP_RLFBCON: begin
                        up_rl_ch  <= 1'b1;
                        up_fb_ch  <= 1'b1;
                        up_con_ch <= 1'b1;
                    end
                    GRP_KC:  up_kc_ch <= 1'b1;
                    GRP_KF:  up_kf_ch <= 1'b1;
                    default: begin
                        up_ams_ch <= 1'b1;
                        up_pms_ch <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jt51_csr_ch_sched.sv
// Self-checking bench for jt51_csr_ch_sched: directed scenarios plus random
// traffic, compared against a queue-based model of the slot/commit rules.
module tb_jt51_csr_ch_sched;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       cen;
    logic [2:0] slot;
    logic       busy;
    logic [7:0] din;
    logic       up_rl_ch, up_fb_ch, up_con_ch, up_kc_ch, up_kf_ch, up_ams_ch, up_pms_ch;

    jt51_csr_ch_sched_if bus ();

    jt51_csr_ch_sched #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .bus       (bus.slave),
        .slot      (slot),
        .busy      (busy),
        .din       (din),
        .up_rl_ch  (up_rl_ch),
        .up_fb_ch  (up_fb_ch),
        .up_con_ch (up_con_ch),
        .up_kc_ch  (up_kc_ch),
        .up_kf_ch  (up_kf_ch),
        .up_ams_ch (up_ams_ch),
        .up_pms_ch (up_pms_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int grp;
        int data;
    } mwr_t;

    mwr_t mq[$];
    int   mslot;
    int   mgrp;
    int   mdin;
    int   checks;
    int   errors;

    function automatic logic [6:0] exp_strobes(input int grp);
        case (grp)
            0:       return 7'b1110000;
            1:       return 7'b0001000;
            2:       return 7'b0000100;
            3:       return 7'b0000011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] obs_strobes();
        return {up_rl_ch, up_fb_ch, up_con_ch, up_kc_ch, up_kf_ch, up_ams_ch, up_pms_ch};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clk: drive inputs at negedge, advance the model, check just after posedge.
    task automatic applyStimulus(input logic r, input logic c, input logic v,
                                 input logic [7:0] a, input logic [7:0] d, output logic acc);
        logic ready;
        int   nxt;
        mwr_t e;
        @(negedge clk);
        rst          = r;
        cen          = c;
        bus.wr_valid = v;
        bus.wr_addr  = a;
        bus.wr_din   = d;
        acc          = 1'b0;
        #1;
        if (r) begin
            mq.delete();
            mslot = 0;
            mgrp  = -1;
            mdin  = 0;
        end else begin
            ready = (mq.size() < DEPTH);
            checkOutput("wr_ready", {31'd0, bus.wr_ready}, {31'd0, ready});
            acc = v && ready;
            if (c) begin
                nxt = (mslot + 1) % 8;
                if (mq.size() > 0 && mq[0].ch == nxt) begin
                    mgrp = mq[0].grp;
                    mdin = mq[0].data;
                    void'(mq.pop_front());
                end else begin
                    mgrp = -1;
                end
                mslot = nxt;
            end
            if (acc && a >= 8'h20 && a <= 8'h3F) begin
                e.ch   = int'(a[2:0]);
                e.grp  = int'(a[4:3]);
                e.data = int'(d);
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        checkOutput("slot", {29'd0, slot}, mslot);
        checkOutput("strobes", {25'd0, obs_strobes()}, {25'd0, exp_strobes(mgrp)});
        checkOutput("din", {24'd0, din}, mdin);
        checkOutput("busy", {31'd0, busy}, {31'd0, (mq.size() != 0) || (mgrp >= 0)});
    endtask

    task automatic advanceTo(input int target);
        logic acc;
        for (int i = 0; i < 8 && mslot != target; i++) applyStimulus(0, 1, 0, 8'h00, 8'h00, acc);
        checkOutput("advance_slot", {29'd0, slot}, target);
    endtask

    initial begin
        logic acc;
        int   hits, hit_slot, hit_din, other;
        int   hslot[2];
        int   hdin[2];
        int   accepted_n, wait_n;
        logic [7:0] ra;

        checks = 0;
        errors = 0;
        mslot  = 0;
        mgrp   = -1;
        mdin   = 0;
        rst = 1'b1; cen = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_addr = 8'h00; bus.wr_din = 8'h00;

        applyStimulus(1, 0, 0, 8'h00, 8'h00, acc);
        applyStimulus(1, 1, 1, 8'h21, 8'h55, acc);
        checkOutput("rst_slot", {29'd0, slot}, 0);
        checkOutput("rst_busy", {31'd0, busy}, 0);
        checkOutput("rst_din", {24'd0, din}, 0);
        checkOutput("rst_strobes", {25'd0, obs_strobes()}, 0);
        checkOutput("rst_wr_ready", {31'd0, bus.wr_ready}, 1);

        $display("[TB] idle ring");
        repeat (20) applyStimulus(0, 1, 0, 8'h00, 8'h00, acc);

        $display("[TB] single kc write");
        advanceTo(0);
        applyStimulus(0, 0, 1, 8'h2B, 8'h45, acc);
        hits = 0; other = 0; hit_slot = -1; hit_din = -1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 8'h00, 8'h00, acc);
            if (up_kc_ch) begin hits++; hit_slot = slot; hit_din = din; end
            if (obs_strobes() & 7'b1110111) other++;
        end
        checkOutput("t2_kc_hits", hits, 1);
        checkOutput("t2_kc_slot", hit_slot, 3);
        checkOutput("t2_kc_din", hit_din, 8'h45);
        checkOutput("t2_other", other, 0);
        checkOutput("t2_busy", {31'd0, busy}, 0);

        $display("[TB] rl/fb/con write");
        applyStimulus(0, 0, 1, 8'h25, 8'hC7, acc);
        hits = 0; hit_slot = -1; hit_din = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 8'h00, 8'h00, acc);
            if (up_rl_ch && up_fb_ch && up_con_ch) begin hits++; hit_slot = slot; hit_din = din; end
        end
        checkOutput("t3_hits", hits, 1);
        checkOutput("t3_slot", hit_slot, 5);
        checkOutput("t3_rl", hit_din / 64, 3);
        checkOutput("t3_fb", (hit_din / 8) % 8, 0);
        checkOutput("t3_con", hit_din % 8, 7);

        $display("[TB] back-to-back ams/pms writes");
        advanceTo(2);
        applyStimulus(0, 0, 1, 8'h3F, 8'h31, acc);
        applyStimulus(0, 0, 1, 8'h38, 8'h12, acc);
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 8'h00, 8'h00, acc);
            if (up_ams_ch && up_pms_ch) begin
                if (hits < 2) begin hslot[hits] = slot; hdin[hits] = din; end
                hits++;
            end
        end
        checkOutput("t4_hits", hits, 2);
        checkOutput("t4_slot0", hslot[0], 7);
        checkOutput("t4_din0", hdin[0], 8'h31);
        checkOutput("t4_slot1", hslot[1], 0);
        checkOutput("t4_din1", hdin[1], 8'h12);

        $display("[TB] queue full");
        accepted_n = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 8'h30, 8'(i + 1), acc);
            if (acc) accepted_n++;
        end
        checkOutput("t5_accepted", accepted_n, 4);
        checkOutput("t5_ready_low", {31'd0, bus.wr_ready}, 0);
        hits = 0; other = 0; wait_n = 0; acc = 1'b0;
        while (!acc && wait_n < 40) begin
            applyStimulus(0, 1, 1, 8'h30, 8'h05, acc);
            if (up_kf_ch) begin hits++; if (slot != 3'd0) other++; end
            wait_n++;
        end
        checkOutput("t5_fifth_accepted", {31'd0, acc}, 1);
        for (int i = 0; i < 40 && (mq.size() != 0 || mgrp >= 0); i++) begin
            applyStimulus(0, 1, 0, 8'h00, 8'h00, acc);
            if (up_kf_ch) begin hits++; if (slot != 3'd0) other++; end
        end
        checkOutput("t5_kf_hits", hits, 5);
        checkOutput("t5_kf_wrong_slot", other, 0);

        $display("[TB] reset discards pending writes");
        advanceTo(0);
        applyStimulus(0, 0, 1, 8'h10, 8'h77, acc);
        applyStimulus(0, 1, 1, 8'h2A, 8'h99, acc);
        applyStimulus(1, 0, 0, 8'h00, 8'h00, acc);
        checkOutput("t6_slot", {29'd0, slot}, 0);
        checkOutput("t6_busy", {31'd0, busy}, 0);
        other = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1, 0, 8'h00, 8'h00, acc);
            if (obs_strobes() != 7'd0) other++;
        end
        checkOutput("t6_no_strobes", other, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) ra = 8'($urandom_range(0, 255));
            else ra = 8'h20 + 8'($urandom_range(0, 31));
            applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 2) == 0), ra, 8'($urandom_range(0, 255)), acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
